typed_value_unpacker: RTL

- Receiver end of the typed-value byte stream: accepts a header byte plus little-endian payload bytes for one SystemVerilog integral type (byte, shortint, int, longint).
- Reassembles the value, sign- or zero-extends it to 64 bits, and presents it with its type code and bit width (the $bits value of the type).
- Sits between the stream packer/transport and the checker logic that compares decoded values and widths against expectations.

---
 rtl/typed_value_unpacker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/typed_value_unpacker.sv
`default_nettype none
// ============================================================================
// typed_value_unpacker
// Rebuilds byte/shortint/int/longint values from a header + little-endian
// payload byte stream and presents them sign/zero-extended to 64 bits.
// Revision: 1.0 - initial release
// ============================================================================
module typed_value_unpacker #(
  parameter int WD     = 8,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [WD-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [63:0]   m_data,
  output logic [1:0]    m_type,
  output logic [6:0]    m_bits,
  output logic          m_signed,
  output logic          err,
  output logic [7:0]    err_cnt
);

  localparam int c_to_w = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [c_to_w-1:0] c_to_last = (TO_CYC == 0) ? '0 : c_to_w'(TO_CYC - 1);

  generate
    if (WD != 8) begin : g_bad_wd
      $error("typed_value_unpacker: WD must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s_ready;
  logic [1:0]  r_type;
  logic        r_sgn;
  logic [2:0]  r_cnt;
  logic [c_to_w-1:0] r_to_cnt;
  logic [63:0] r_asm;
  logic        r_m_valid;
  logic [63:0] r_m_data;
  logic [1:0]  r_m_type;
  logic [6:0]  r_m_bits;
  logic        r_m_signed;
  logic        r_err;
  logic [7:0]  r_err_cnt;

  logic        w_accept;
  logic        w_hdr_ok;
  logic        w_timeout;
  logic        w_hdr_take;
  logic        w_go_out;
  logic        w_err_set;
  logic [2:0]  w_last_idx;
  logic [63:0] w_full;
  logic [63:0] w_ext;

  assign w_accept  = s_valid & r_s_ready;
  assign w_hdr_ok  = (s_data[7:3] == 5'd0);
  assign w_timeout = (TO_CYC != 0) && (r_to_cnt == c_to_last);

  always_comb begin
    w_last_idx = 3'd0;
    case (r_type)
      2'd0:    w_last_idx = 3'd0;
      2'd1:    w_last_idx = 3'd1;
      2'd2:    w_last_idx = 3'd3;
      default: w_last_idx = 3'd7;
    endcase
  end

  // Final value includes the byte being accepted this cycle, so the
  // extension can be registered on the same edge that enters OUTPUT.
  always_comb begin
    w_full = r_asm;
    w_full[{r_cnt, 3'b000} +: 8] = s_data[7:0];
    w_ext = w_full;
    case (r_type)
      2'd0:    w_ext = {{56{r_sgn & w_full[7]}},  w_full[7:0]};
      2'd1:    w_ext = {{48{r_sgn & w_full[15]}}, w_full[15:0]};
      2'd2:    w_ext = {{32{r_sgn & w_full[31]}}, w_full[31:0]};
      default: w_ext = w_full;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_take  = 1'b0;
    w_go_out    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_hdr_take  = 1'b1;
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          if (r_cnt == w_last_idx) begin
            w_go_out    = 1'b1;
            w_state_nxt = S_OUTPUT;
          end
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (m_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt != S_OUTPUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= 2'd0;
      r_sgn      <= 1'b0;
      r_cnt      <= 3'd0;
      r_to_cnt   <= '0;
      r_asm      <= 64'd0;
      r_m_valid  <= 1'b0;
      r_m_data   <= 64'd0;
      r_m_type   <= 2'd0;
      r_m_bits   <= 7'd0;
      r_m_signed <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_err <= w_err_set;
      if (w_err_set && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_hdr_take) begin
        r_type   <= s_data[1:0];
        r_sgn    <= s_data[2];
        r_asm    <= 64'd0;
        r_cnt    <= 3'd0;
        r_to_cnt <= '0;
      end else if (r_state == S_PAYLOAD) begin
        if (w_accept) begin
          r_asm[{r_cnt, 3'b000} +: 8] <= s_data[7:0];
          r_cnt    <= r_cnt + 3'd1;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end

      if (w_go_out) begin
        r_m_valid  <= 1'b1;
        r_m_data   <= w_ext;
        r_m_type   <= r_type;
        r_m_bits   <= 7'd8 << r_type;
        r_m_signed <= r_sgn;
      end else if ((r_state == S_OUTPUT) && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready  = r_s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_type   = r_m_type;
  assign m_bits   = r_m_bits;
  assign m_signed = r_m_signed;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
